// File: rtl/sum_sub_power_meter_pkg.sv
// Shared types and constants for the sum/difference channel power meter.
// Holds the FSM state encoding, the I/Q field layout and the result latency.
package sum_sub_power_meter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StAccum,
        StFlush
    } state_e;

    localparam int unsigned I_MSB = 31;
    localparam int unsigned I_LSB = 16;
    localparam int unsigned Q_MSB = 15;
    localparam int unsigned Q_LSB = 0;

    // Accepted eop cycle to pwr_valid, in clock cycles.
    localparam int unsigned PIPE_LATENCY = 5;

endpackage

// File: rtl/iq_power_sq.sv
// Two-stage registered I^2 + Q^2 for one packed signed I/Q sample.
// Free-running: qualification flags travel alongside in the instantiating module.
module iq_power_sq
    import sum_sub_power_meter_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [31:0] iq,
    output logic [31:0] power
);

    logic signed [15:0] i_s;
    logic signed [15:0] q_s;
    logic [31:0] i_sq_q;
    logic [31:0] q_sq_q;
    logic [31:0] power_q;

    assign i_s = iq[I_MSB:I_LSB];
    assign q_s = iq[Q_MSB:Q_LSB];

    // Each square is at most 2^30, so the sum always fits in 32 unsigned bits.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            i_sq_q  <= '0;
            q_sq_q  <= '0;
            power_q <= '0;
        end else begin
            i_sq_q  <= 32'(32'(i_s) * 32'(i_s));
            q_sq_q  <= 32'(32'(q_s) * 32'(q_s));
            power_q <= i_sq_q + q_sq_q;
        end
    end

    assign power = power_q;

endmodule

// File: rtl/sum_sub_power_meter.sv
// Frame power meter for paired sum/difference ADC channels with framing-error detection.
// Define POWER_METER_LEN_CHECK_EN to also flag frames whose sample count differs from frame_len.
module sum_sub_power_meter
    import sum_sub_power_meter_pkg::*;
#(
    parameter int unsigned ACC_W = 48,
    parameter int unsigned CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             adc_data_sum_sop,
    input  logic             adc_data_sum_eop,
    input  logic             adc_data_sum_valid,
    input  logic [31:0]      adc_data_sum,
    input  logic             adc_data_sub_sop,
    input  logic             adc_data_sub_eop,
    input  logic             adc_data_sub_valid,
    input  logic [31:0]      adc_data_sub,
    input  logic             arm,
    input  logic [CNT_W-1:0] frame_len,
    output logic [ACC_W-1:0] pwr_sum,
    output logic [ACC_W-1:0] pwr_sub,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             pwr_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam logic [2:0] FLUSH_LAST = 3'(PIPE_LATENCY - 2);

    state_e     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       err_q, err_d;
    logic       accept, capture, load_out, frame_err_d;

    logic        s1_valid_q, s1_sop_q, s2_valid_q, s2_sop_q, s3_valid_q, s3_sop_q;
    logic [31:0] s1_sum_q, s1_sub_q, s3_pwr_sum, s3_pwr_sub;

    logic [ACC_W-1:0] acc_sum_q, acc_sub_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W:0]   acc_sum_add, acc_sub_add;

    logic [ACC_W-1:0] pwr_sum_q, pwr_sub_q;
    logic [CNT_W-1:0] sample_cnt_q;
    logic             pwr_valid_q, frame_err_q;

    logic unused_inputs;

    assign accept  = adc_data_sum_valid & adc_data_sub_valid;
    assign capture = accept & (((state_q == StArmed) & adc_data_sum_sop) | (state_q == StAccum));

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        err_d       = err_q;
        load_out    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arm) state_d = StArmed;
            end
            StArmed: begin
                if (accept && adc_data_sum_sop) begin
                    err_d       = 1'b0;
                    flush_cnt_d = '0;
                    state_d     = adc_data_sum_eop ? StFlush : StAccum;
                end
            end
            StAccum: begin
                if (adc_data_sum_valid ^ adc_data_sub_valid) err_d = 1'b1;
                if (accept && adc_data_sum_sop) err_d = 1'b1;
                if (accept && adc_data_sum_eop) begin
                    flush_cnt_d = '0;
                    state_d     = StFlush;
                end
            end
            StFlush: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    load_out = 1'b1;
                    state_d  = StIdle;
                end else begin
                    flush_cnt_d = flush_cnt_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    // Input register; the sop flag follows each sample so the accumulator clears on it.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_sum_q   <= '0;
            s1_sub_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_sop_q   <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_sop_q   <= 1'b0;
        end else begin
            s1_valid_q <= capture;
            s1_sop_q   <= capture & adc_data_sum_sop;
            if (capture) begin
                s1_sum_q <= adc_data_sum;
                s1_sub_q <= adc_data_sub;
            end
            s2_valid_q <= s1_valid_q;
            s2_sop_q   <= s1_sop_q;
            s3_valid_q <= s2_valid_q;
            s3_sop_q   <= s2_sop_q;
        end
    end

    iq_power_sq u_sq_sum (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .iq      (s1_sum_q),
        .power   (s3_pwr_sum)
    );

    iq_power_sq u_sq_sub (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .iq      (s1_sub_q),
        .power   (s3_pwr_sub)
    );

    assign acc_sum_add = {1'b0, acc_sum_q} + (ACC_W + 1)'(s3_pwr_sum);
    assign acc_sub_add = {1'b0, acc_sub_q} + (ACC_W + 1)'(s3_pwr_sub);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum_q <= '0;
            acc_sub_q <= '0;
            cnt_q     <= '0;
        end else if (s3_valid_q) begin
            if (s3_sop_q) begin
                acc_sum_q <= ACC_W'(s3_pwr_sum);
                acc_sub_q <= ACC_W'(s3_pwr_sub);
                cnt_q     <= CNT_W'(1);
            end else begin
                acc_sum_q <= acc_sum_add[ACC_W] ? '1 : acc_sum_add[ACC_W-1:0];
                acc_sub_q <= acc_sub_add[ACC_W] ? '1 : acc_sub_add[ACC_W-1:0];
                cnt_q     <= (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef POWER_METER_LEN_CHECK_EN
    assign frame_err_d   = err_q | (cnt_q != frame_len);
    assign unused_inputs = ^{adc_data_sub_sop, adc_data_sub_eop};
`else
    assign frame_err_d   = err_q;
    assign unused_inputs = ^{adc_data_sub_sop, adc_data_sub_eop, frame_len};
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_sum_q    <= '0;
            pwr_sub_q    <= '0;
            sample_cnt_q <= '0;
            frame_err_q  <= 1'b0;
            pwr_valid_q  <= 1'b0;
        end else begin
            pwr_valid_q <= load_out;
            if (load_out) begin
                pwr_sum_q    <= acc_sum_q;
                pwr_sub_q    <= acc_sub_q;
                sample_cnt_q <= cnt_q;
                frame_err_q  <= frame_err_d;
            end
        end
    end

    assign pwr_sum    = pwr_sum_q;
    assign pwr_sub    = pwr_sub_q;
    assign sample_cnt = sample_cnt_q;
    assign frame_err  = frame_err_q;
    assign pwr_valid  = pwr_valid_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/sum_sub_power_meter.md
SUM_SUB_POWER_METER -- requirements
Module: sum_sub_power_meter

Interface
REQ-001 SHALL have parameter ACC_W, default 48, power accumulator width.
REQ-002 SHALL have parameter CNT_W, default 16, sample counter and frame length width.
REQ-003 SHALL have port sys_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports adc_data_sum_sop/eop/valid  input  1 each  sum-channel framing.
REQ-006 SHALL have port adc_data_sum  input  32  signed I[31:16], Q[15:0].
REQ-007 SHALL have ports adc_data_sub_sop/eop/valid  input  1 each  difference-channel framing.
REQ-008 SHALL have port adc_data_sub  input  32  signed I[31:16], Q[15:0].
REQ-009 SHALL have port arm  input  1  single-cycle request to measure the next frame.
REQ-010 SHALL have port frame_len  input  CNT_W  expected samples per frame.
REQ-011 SHALL have port pwr_sum  output  ACC_W  unsigned sum of I^2+Q^2 over the sum channel.
REQ-012 SHALL have port pwr_sub  output  ACC_W  same, difference channel.
REQ-013 SHALL have port sample_cnt  output  CNT_W  samples accumulated.
REQ-014 SHALL have port pwr_valid  output  1  one-cycle result strobe.
REQ-015 SHALL have port busy  output  1  high in ARMED, ACCUM and FLUSH.
REQ-016 SHALL have port frame_err  output  1  framing error flag, qualified by pwr_valid.

Function
REQ-017 A sample SHALL be accepted only when adc_data_sum_valid and adc_data_sub_valid are both high; sop/eop SHALL be taken from the sum channel.
REQ-018 FSM SHALL have states IDLE, ARMED, ACCUM, FLUSH: IDLE->ARMED on arm; ARMED->ACCUM on accepted sop; ACCUM->FLUSH on accepted eop; FLUSH->IDLE after 4 cycles with pwr_valid.
REQ-019 Pipeline SHALL be input register, squares, I^2+Q^2 (32-bit unsigned), accumulate; pwr_valid SHALL rise exactly 5 cycles after the accepted eop cycle.
REQ-020 Sop and eop samples SHALL both be included; a sample with sop and eop together SHALL form a 1-sample frame.
REQ-021 Accumulators SHALL clear at the sop sample; sample_cnt SHALL saturate at 2^CNT_W-1; accumulators SHALL saturate at all ones.
REQ-022 An accepted sop in ACCUM SHALL restart the frame and set a sticky error reported with the result.
REQ-023 Any cycle in ACCUM with exactly one channel valid SHALL set the sticky error.
REQ-024 In IDLE/ARMED, eop SHALL be ignored; arm outside IDLE SHALL be ignored.
REQ-025 pwr_sum, pwr_sub, sample_cnt, frame_err SHALL update only on the pwr_valid cycle and hold until the next one.

Reset
REQ-026 Asserting rst_n low SHALL, at any state including mid-frame, force IDLE and zero all outputs and pipeline valids immediately; no pwr_valid SHALL follow.

Configuration
REQ-027 With POWER_METER_LEN_CHECK_EN defined, frame_err SHALL also be set when final sample_cnt != frame_len.
REQ-028 Without POWER_METER_LEN_CHECK_EN, frame_len SHALL be ignored and only REQ-022/023 SHALL set frame_err.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the 32-bit I/Q field offsets and the pipeline latency constant 5.
REQ-030 One sub-module, iq_power_sq, SHALL compute registered I^2+Q^2 and be instantiated per channel.

Verification
REQ-031 arm; 4 samples sum=(100,0), sub=(3,4) -> pwr_sum=40000, pwr_sub=100, sample_cnt=4, frame_err=0, pwr_valid at eop+5.
REQ-032 2 samples sum=(-32768,-32768) -> pwr_sum=4294967296, no overflow.
REQ-033 LEN_CHECK_EN, frame_len=8, eop on 6th sample -> frame_err=1, sample_cnt=6; macro undefined -> frame_err=0.
REQ-034 Second sop after 3 samples, frame of 5 from there -> sample_cnt=5, frame_err=1.
REQ-035 Valid gaps of 2 cycles between 4 samples -> same result as REQ-031; one sub-only valid cycle -> frame_err=1.
REQ-036 rst_n low mid-ACCUM, then release -> outputs 0, busy=0, no pwr_valid; eop without arm -> no pwr_valid.
